// File: rtl/bus_demux_1_2_pkg.sv
// Shared constants for the 1-to-2 data-memory bus demultiplexer.
//   - FSM state encodings (2-bit constant set)
//   - default decode window for target 1 (MMIO)
//   - default wait-cycle limit used when BUS_TIMEOUT_EN is defined
package bus_demux_1_2_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [31:0] T1_BASE_DEF = 32'h1001_0000;
    localparam logic [31:0] T1_MASK_DEF = 32'hFFFF_0000;

    localparam int TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decode: sel = 1 when addr falls inside the
// target 1 window ((addr & T1_MASK) == T1_BASE), otherwise 0.
// Ports:
//   addr  in   ADDR_LENGTH  byte address to decode
//   sel   out  1            0 = target 0 (RAM), 1 = target 1 (MMIO)
module bus_addr_decode
    import bus_demux_1_2_pkg::*;
#(
    parameter int                     ADDR_LENGTH = 32,
    parameter logic [ADDR_LENGTH-1:0] T1_BASE     = T1_BASE_DEF,
    parameter logic [ADDR_LENGTH-1:0] T1_MASK     = T1_MASK_DEF
)(
    input  logic [ADDR_LENGTH-1:0] addr,
    output logic                   sel
);

    assign sel = ((addr & T1_MASK) == T1_BASE);

endmodule

// File: rtl/bus_demux_1_2.sv
// Sequential 1-to-2 bus demultiplexer for the data-memory side of the core.
// One load/store request is latched in IDLE, decoded to target 0 (RAM) or
// target 1 (MMIO), handed to that target with a req/ack handshake, and the
// result is returned to the core as a one-cycle cpu_ready pulse.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   - ACCESS gives up after TIMEOUT_CYCLES cycles without ack and
//               completes with cpu_err = 1, cpu_rdata = 0
//   undefined - ACCESS waits for ack indefinitely, cpu_err tied to 0
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   cpu_req/we/addr/wdata    core request (held until cpu_ready)
//   cpu_rdata/ready/err      core response, valid while cpu_ready = 1
//   tN_req/we/addr/wdata     target N request (registered)
//   tN_rdata/ack             target N response, rdata valid with ack
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for cpu_req; latches decode and request fields
// ST_ACCESS  | tN_req asserted toward the latched target, waiting for ack
// ST_DONE    | cpu_ready pulse (one cycle), then back to ST_IDLE
module bus_demux_1_2
    import bus_demux_1_2_pkg::*;
#(
    parameter int                     DATA_LENGTH    = 32,
    parameter int                     ADDR_LENGTH    = 32,
    parameter logic [ADDR_LENGTH-1:0] T1_BASE        = T1_BASE_DEF,
    parameter logic [ADDR_LENGTH-1:0] T1_MASK        = T1_MASK_DEF,
    parameter int                     TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_LENGTH-1:0] cpu_addr,
    input  logic [DATA_LENGTH-1:0] cpu_wdata,
    output logic [DATA_LENGTH-1:0] cpu_rdata,
    output logic                   cpu_ready,
    output logic                   cpu_err,
    output logic                   t0_req,
    output logic                   t0_we,
    output logic [ADDR_LENGTH-1:0] t0_addr,
    output logic [DATA_LENGTH-1:0] t0_wdata,
    input  logic [DATA_LENGTH-1:0] t0_rdata,
    input  logic                   t0_ack,
    output logic                   t1_req,
    output logic                   t1_we,
    output logic [ADDR_LENGTH-1:0] t1_addr,
    output logic [DATA_LENGTH-1:0] t1_wdata,
    input  logic [DATA_LENGTH-1:0] t1_rdata,
    input  logic                   t1_ack
);

    logic [1:0]             state_q, state_d;
    logic                   sel_q, sel_d;
    logic [DATA_LENGTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic                   cpu_ready_q, cpu_ready_d;
    logic                   t0_req_q, t0_req_d, t0_we_q, t0_we_d;
    logic [ADDR_LENGTH-1:0] t0_addr_q, t0_addr_d;
    logic [DATA_LENGTH-1:0] t0_wdata_q, t0_wdata_d;
    logic                   t1_req_q, t1_req_d, t1_we_q, t1_we_d;
    logic [ADDR_LENGTH-1:0] t1_addr_q, t1_addr_d;
    logic [DATA_LENGTH-1:0] t1_wdata_q, t1_wdata_d;

    logic                   dec_sel;
    logic                   ack_sel;
    logic                   we_sel;
    logic [DATA_LENGTH-1:0] rdata_sel;
    logic                   finish;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cpu_err_q, cpu_err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    bus_addr_decode #(
        .ADDR_LENGTH (ADDR_LENGTH),
        .T1_BASE     (T1_BASE),
        .T1_MASK     (T1_MASK)
    ) u_decode (
        .addr (cpu_addr),
        .sel  (dec_sel)
    );

    // Only the latched target's handshake is looked at; the other is ignored.
    always_comb begin
        ack_sel   = sel_q ? t1_ack   : t0_ack;
        rdata_sel = sel_q ? t1_rdata : t0_rdata;
        we_sel    = sel_q ? t1_we_q  : t0_we_q;
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        t0_req_d    = t0_req_q;
        t0_we_d     = t0_we_q;
        t0_addr_d   = t0_addr_q;
        t0_wdata_d  = t0_wdata_q;
        t1_req_d    = t1_req_q;
        t1_we_d     = t1_we_q;
        t1_addr_d   = t1_addr_q;
        t1_wdata_d  = t1_wdata_q;
        finish      = 1'b0;
`ifdef BUS_TIMEOUT_EN
        cnt_d       = cnt_q;
        cpu_err_d   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    state_d    = ST_ACCESS;
                    sel_d      = dec_sel;
                    // Request fields live directly in the target registers,
                    // so the non-selected side is loaded with zeros.
                    t0_req_d   = ~dec_sel;
                    t0_we_d    = ~dec_sel & cpu_we;
                    t0_addr_d  = dec_sel ? '0 : cpu_addr;
                    t0_wdata_d = dec_sel ? '0 : cpu_wdata;
                    t1_req_d   = dec_sel;
                    t1_we_d    = dec_sel & cpu_we;
                    t1_addr_d  = dec_sel ? cpu_addr  : '0;
                    t1_wdata_d = dec_sel ? cpu_wdata : '0;
`ifdef BUS_TIMEOUT_EN
                    cnt_d      = CNT_LOAD;
`endif
                end
            end
            ST_ACCESS: begin
                // Ack on the expiry cycle takes priority over the timeout.
                if (ack_sel) begin
                    finish      = 1'b1;
                    cpu_rdata_d = we_sel ? '0 : rdata_sel;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    finish      = 1'b1;
                    cpu_rdata_d = '0;
                    cpu_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish) begin
            state_d     = ST_DONE;
            cpu_ready_d = 1'b1;
            t0_req_d    = 1'b0;
            t0_we_d     = 1'b0;
            t0_addr_d   = '0;
            t0_wdata_d  = '0;
            t1_req_d    = 1'b0;
            t1_we_d     = 1'b0;
            t1_addr_d   = '0;
            t1_wdata_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            t0_req_q    <= 1'b0;
            t0_we_q     <= 1'b0;
            t0_addr_q   <= '0;
            t0_wdata_q  <= '0;
            t1_req_q    <= 1'b0;
            t1_we_q     <= 1'b0;
            t1_addr_q   <= '0;
            t1_wdata_q  <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= '0;
            cpu_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            t0_req_q    <= t0_req_d;
            t0_we_q     <= t0_we_d;
            t0_addr_q   <= t0_addr_d;
            t0_wdata_q  <= t0_wdata_d;
            t1_req_q    <= t1_req_d;
            t1_we_q     <= t1_we_d;
            t1_addr_q   <= t1_addr_d;
            t1_wdata_q  <= t1_wdata_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
            cpu_err_q   <= cpu_err_d;
`endif
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign t0_req    = t0_req_q;
    assign t0_we     = t0_we_q;
    assign t0_addr   = t0_addr_q;
    assign t0_wdata  = t0_wdata_q;
    assign t1_req    = t1_req_q;
    assign t1_we     = t1_we_q;
    assign t1_addr   = t1_addr_q;
    assign t1_wdata  = t1_wdata_q;
`ifdef BUS_TIMEOUT_EN
    assign cpu_err   = cpu_err_q;
`else
    assign cpu_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_demux_1_2.sv
// Self-checking bench for bus_demux_1_2. Expected values come from a small
// behavioural model: target 1 owns the 64 KiB window 0x1001_0000..0x1001_FFFF,
// loads return the acking target's data, stores return 0, and cpu_ready is
// seen by the core (waits + 2) clock edges after the edge that samples cpu_req.
module tb_bus_demux_1_2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready, cpu_err;
    logic        t0_req, t0_we, t0_ack, t1_req, t1_we, t1_ack;
    logic [31:0] t0_addr, t0_wdata, t0_rdata, t1_addr, t1_wdata, t1_rdata;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit overlap_seen = 1'b0;
    bit ready_long   = 1'b0;
    bit ready_prev   = 1'b0;

    bus_demux_1_2 dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .t0_req(t0_req), .t0_we(t0_we), .t0_addr(t0_addr), .t0_wdata(t0_wdata),
        .t0_rdata(t0_rdata), .t0_ack(t0_ack),
        .t1_req(t1_req), .t1_we(t1_we), .t1_addr(t1_addr), .t1_wdata(t1_wdata),
        .t1_rdata(t1_rdata), .t1_ack(t1_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (t0_req && t1_req) overlap_seen = 1'b1;
        if (cpu_ready && ready_prev) ready_long = 1'b1;
        ready_prev = cpu_ready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic model_sel(input logic [31:0] a);
        return (a >= 32'h1001_0000) && (a <= 32'h1001_FFFF);
    endfunction

    // Drives one core transaction and plays the selected target, acking in
    // ACCESS cycle number waits+1. Returns what the core observed.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] ack_data,
                           input bit stray_every, input bit hold,
                           output bit got, output int lat, output logic [31:0] rd,
                           output logic er, output bit stable, output int ready_cyc);
        logic s;
        logic [31:0] junk;
        s = model_sel(addr);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk); #1;
        cpu_we = ~we; junk = $urandom; cpu_addr = junk; junk = $urandom; cpu_wdata = junk;
        got = 1'b0; lat = 0; stable = 1'b1; rd = '0; er = 1'b0; ready_cyc = 0;
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge clk);
            if (cpu_ready) begin
                got = 1'b1; rd = cpu_rdata; er = cpu_err; ready_cyc = cyc;
                if (!hold) cpu_req = 1'b0;
            end else begin
                if (s) begin
                    if (!(t1_req && t1_we == we && t1_addr == addr && t1_wdata == wdata &&
                          !t0_req && !t0_we && t0_addr == 0 && t0_wdata == 0)) stable = 1'b0;
                end else begin
                    if (!(t0_req && t0_we == we && t0_addr == addr && t0_wdata == wdata &&
                          !t1_req && !t1_we && t1_addr == 0 && t1_wdata == 0)) stable = 1'b0;
                end
                if (c == waits) begin
                    if (s) begin t1_ack = 1'b1; t1_rdata = ack_data; end
                    else   begin t0_ack = 1'b1; t0_rdata = ack_data; end
                end
                if (stray_every || $urandom_range(0, 1) == 1) begin
                    junk = $urandom;
                    if (s) begin t0_ack = 1'b1; t0_rdata = junk; end
                    else   begin t1_ack = 1'b1; t1_rdata = junk; end
                end
            end
            @(posedge clk); lat++; #1;
            t0_ack = 1'b0; t1_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        t0_ack = 1'b0; t1_ack = 1'b0; t0_rdata = '0; t1_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({cpu_ready, cpu_err, cpu_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_cpu: got ready=%b err=%b rdata=%h, expected all 0", cpu_ready, cpu_err, cpu_rdata);
        end
        vectors++;
        if ({t0_req, t0_we, t0_addr, t0_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_t0: got req=%b we=%b addr=%h wdata=%h, expected all 0", t0_req, t0_we, t0_addr, t0_wdata);
        end
        vectors++;
        if ({t1_req, t1_we, t1_addr, t1_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_t1: got req=%b we=%b addr=%h wdata=%h, expected all 0", t1_req, t1_we, t1_addr, t1_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_ram_load();
        bit got, st; int lat, rc; logic [31:0] rd; logic er;
        run_txn(1'b0, 32'h1000_0004, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1'b0, got, lat, rd, er, st, rc);
        vectors++;
        if (!got || lat !== 2) begin miscompares++; $display("FAIL ram_load_latency: got done=%b lat=%0d, expected 1/2", got, lat); end
        vectors++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin miscompares++; $display("FAIL ram_load_data: got %h err=%b, expected deadbeef err=0", rd, er); end
        vectors++;
        if (!st) begin miscompares++; $display("FAIL ram_load_target: got unstable/wrong target outputs, expected t0 only"); end
    endtask

    task automatic test_mmio_store();
        bit got, st; int lat, rc; logic [31:0] rd; logic er;
        run_txn(1'b1, 32'h1001_0008, 32'h0000_00A5, 4, 32'h1234_5678, 1'b0, 1'b0, got, lat, rd, er, st, rc);
        vectors++;
        if (!got || lat !== 6) begin miscompares++; $display("FAIL mmio_store_latency: got done=%b lat=%0d, expected 1/6", got, lat); end
        vectors++;
        if (rd !== 32'h0 || er !== 1'b0) begin miscompares++; $display("FAIL mmio_store_rdata: got %h err=%b, expected 0 err=0", rd, er); end
        vectors++;
        if (!st) begin miscompares++; $display("FAIL mmio_store_target: got unstable/wrong t1 outputs, expected stable t1 store"); end
    endtask

    task automatic test_back_to_back();
        bit g1, g2, s1, s2; int l1, l2, c1, c2; logic [31:0] r1, r2; logic e1, e2;
        run_txn(1'b0, 32'h0000_0100, 32'h0, 0, 32'hA0A0_0001, 1'b0, 1'b1, g1, l1, r1, e1, s1, c1);
        run_txn(1'b0, 32'h1001_0010, 32'h0, 0, 32'hB0B0_0002, 1'b0, 1'b0, g2, l2, r2, e2, s2, c2);
        vectors++;
        if (!g1 || !g2 || (c2 - c1) !== 3) begin miscompares++; $display("FAIL b2b_spacing: got %0d cycles apart, expected 3", c2 - c1); end
        vectors++;
        if (r1 !== 32'hA0A0_0001 || r2 !== 32'hB0B0_0002) begin miscompares++; $display("FAIL b2b_data: got %h/%h, expected a0a00001/b0b00002", r1, r2); end
        vectors++;
        if (!s1 || !s2 || overlap_seen) begin miscompares++; $display("FAIL b2b_targets: got stable=%b%b overlap=%b, expected 11/0", s1, s2, overlap_seen); end
        vectors++;
        if (ready_long) begin miscompares++; $display("FAIL ready_pulse: got cpu_ready high >1 cycle, expected single-cycle pulse"); end
    endtask

    task automatic test_stray_acks();
        bit got, st, bad; int lat, rc; logic [31:0] rd, junk; logic er;
        bad = 1'b0;
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            junk = $urandom; t0_rdata = junk; t0_ack = 1'b1; t1_ack = i[0];
            @(posedge clk); #1;
            t0_ack = 1'b0; t1_ack = 1'b0;
            if (cpu_ready || t0_req || t1_req) bad = 1'b1;
        end
        vectors++;
        if (bad) begin miscompares++; $display("FAIL stray_idle: got activity from idle acks, expected none"); end
        run_txn(1'b0, 32'h2000_0000, 32'h0, 3, 32'h5555_AAAA, 1'b1, 1'b0, got, lat, rd, er, st, rc);
        vectors++;
        if (!got || lat !== 5 || rd !== 32'h5555_AAAA) begin
            miscompares++; $display("FAIL stray_access: got done=%b lat=%0d rdata=%h, expected 1/5/5555aaaa", got, lat, rd);
        end
    endtask

    task automatic test_reset_mid_access();
        bit got, st; int lat, rc; logic [31:0] rd; logic er;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1001_0020; cpu_wdata = '0;
        @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (t1_req !== 1'b1) begin miscompares++; $display("FAIL mid_rst_pre: got t1_req=%b, expected 1", t1_req); end
        rst = 1'b1; #1;
        vectors++;
        if ({t0_req, t1_req, cpu_ready} !== 3'b000) begin
            miscompares++; $display("FAIL mid_rst_async: got t0_req=%b t1_req=%b ready=%b, expected 000", t0_req, t1_req, cpu_ready);
        end
        cpu_req = 1'b0;
        @(negedge clk); rst = 1'b0;
        run_txn(1'b0, 32'h1001_0024, 32'h0, 1, 32'hC0FF_EE00, 1'b0, 1'b0, got, lat, rd, er, st, rc);
        vectors++;
        if (!got || lat !== 3 || rd !== 32'hC0FF_EE00 || !st) begin
            miscompares++; $display("FAIL mid_rst_after: got done=%b lat=%0d rdata=%h stable=%b, expected 1/3/c0ffee00/1", got, lat, rd, st);
        end
    endtask

    task automatic test_random();
        logic [31:0] edges [4];
        edges[0] = 32'h1000_FFFF; edges[1] = 32'h1001_0000;
        edges[2] = 32'h1001_FFFF; edges[3] = 32'h1002_0000;
        for (int n = 0; n < 24; n++) begin
            bit got, st, hold; int lat, rc, waits; logic [31:0] rd, addr, wd, ad, lo, exp_rd; logic er, we;
            lo = $urandom;
            case ($urandom_range(0, 2))
                0: addr = {16'h1001, lo[15:0]};
                1: addr = lo;
                default: addr = edges[n % 4];
            endcase
            we = $urandom_range(0, 1) == 1;
            wd = $urandom; ad = $urandom;
            waits = $urandom_range(0, 7);
            hold = (n != 23) && ($urandom_range(0, 1) == 1);
            exp_rd = we ? 32'h0 : ad;
            run_txn(we, addr, wd, waits, ad, 1'b0, hold, got, lat, rd, er, st, rc);
            vectors++;
            if (!got || lat !== waits + 2 || rd !== exp_rd || er !== 1'b0 || !st) begin
                miscompares++;
                $display("FAIL random_%0d: addr=%h we=%b got done=%b lat=%0d rdata=%h err=%b stable=%b, expected lat=%0d rdata=%h err=0 stable=1",
                         n, addr, we, got, lat, rd, er, st, waits + 2, exp_rd);
            end
        end
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        bit got, st; int lat, rc; logic [31:0] rd; logic er;
        run_txn(1'b0, 32'h1001_0040, 32'h0, 15, 32'h7777_0016, 1'b0, 1'b0, got, lat, rd, er, st, rc);
        vectors++;
        if (!got || lat !== 17 || er !== 1'b0 || rd !== 32'h7777_0016) begin
            miscompares++; $display("FAIL ack_at_limit: got done=%b lat=%0d err=%b rdata=%h, expected 1/17/0/77770016", got, lat, er, rd);
        end
        run_txn(1'b0, 32'h0000_0040, 32'h0, 1000, 32'h0, 1'b0, 1'b0, got, lat, rd, er, st, rc);
        vectors++;
        if (!got || lat !== 17 || er !== 1'b1 || rd !== 32'h0) begin
            miscompares++; $display("FAIL timeout: got done=%b lat=%0d err=%b rdata=%h, expected 1/17/1/0", got, lat, er, rd);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ram_load();
        test_mmio_store();
        test_back_to_back();
        test_stray_acks();
        test_reset_mid_access();
        test_random();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_demux_1_2.md
Name: bus_demux_1_2

Overview:
- Sequential 1-to-2 bus demultiplexer on the MIPS data-memory side.
- Routes one processor load/store request to target 0 (data RAM) or target 1 (MMIO peripherals), selected by address decode.
- Runs a request/acknowledge handshake toward the selected target and steers read data back to the core.
- Allows the multi-cycle control FSM to stall on slow peripherals.

Parameters:
- DATA_LENGTH, 32, data bus width.
- ADDR_LENGTH, 32, address bus width.
- T1_BASE, 32'h1001_0000, base address of the target 1 (MMIO) window.
- T1_MASK, 32'hFFFF_0000, decode mask. Target 1 is selected when (cpu_addr & T1_MASK) == T1_BASE; otherwise target 0.
- TIMEOUT_CYCLES, 16, wait-cycle limit. Used only when BUS_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- cpu_req  in  1  core request. Held high until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_LENGTH  byte address.
- cpu_wdata  in  DATA_LENGTH  store data.
- cpu_rdata  out  DATA_LENGTH  load data. Valid while cpu_ready = 1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  bus error flag. Qualified by cpu_ready.
- t0_req, t1_req  out  1  target request.
- t0_we, t1_we  out  1  target write enable.
- t0_addr, t1_addr  out  ADDR_LENGTH  target address.
- t0_wdata, t1_wdata  out  DATA_LENGTH  target write data.
- t0_rdata, t1_rdata  in  DATA_LENGTH  target read data. Valid with ack.
- t0_ack, t1_ack  in  1  target acknowledge, one cycle.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. All registered outputs clear: cpu_ready = 0, cpu_err = 0, cpu_rdata = 0, tN_req = 0, tN_we = 0, tN_addr = 0, tN_wdata = 0. Timeout counter clears.
- FSM states: IDLE, ACCESS, DONE. Encoded as a 2-bit constant set.
- IDLE:
  - On cpu_req = 1, register sel (address decode), we, addr and wdata, then go to ACCESS.
  - cpu_req = 0 keeps IDLE.
- ACCESS:
  - Assert t[sel]_req with the latched we, addr and wdata.
  - The non-selected target's outputs stay 0.
  - Core inputs are ignored; latched values are used.
  - On t[sel]_ack = 1, capture t[sel]_rdata into cpu_rdata (zero for stores), drop t[sel]_req, and go to DONE.
  - ack from the non-selected target is ignored.
- DONE:
  - Drive cpu_ready = 1 for exactly one cycle, then go to IDLE.
  - cpu_rdata holds its value until the next capture.
- Latency: with ack in the first ACCESS cycle, cpu_ready rises 2 clocks after the clk edge that samples cpu_req. Each extra target wait cycle adds one clock.
- Back-to-back: cpu_req still high in the cycle after DONE starts a new transaction. The minimum period is 3 cycles per access.
- Ack arriving in IDLE or DONE is ignored and causes no state change.
- Decode is evaluated once, on IDLE capture. Address changes during ACCESS have no effect.
- Reset during ACCESS: tN_req drops asynchronously. Targets must tolerate an abandoned request.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS. If TIMEOUT_CYCLES cycles pass without ack, go to DONE with cpu_err = 1 and cpu_rdata = 0, and drop tN_req.
  - Ack on the same cycle the count expires wins: normal completion, cpu_err = 0.
- Undefined: no counter. cpu_err is tied to 0, and ACCESS waits for ack indefinitely.

Decomposition:
- Shared package holds:
  - the state encodings (ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_DONE = 2'd2);
  - the default T1_BASE and T1_MASK constants;
  - the TIMEOUT_CYCLES default.
- One natural sub-module: bus_addr_decode, the combinational mask/compare producing sel. It is reusable when more targets are added.

Test Plan:
- Load from RAM: cpu_addr = 32'h1000_0004, cpu_we = 0; t0 acks after 1 cycle with rdata 32'hDEADBEEF -> t0_req only, t1_req = 0, cpu_ready pulse, cpu_rdata = 32'hDEADBEEF, cpu_err = 0, 3 clocks total.
- Store to MMIO: cpu_addr = 32'h1001_0008, cpu_wdata = 32'h0000_00A5, cpu_we = 1; t1 acks after 4 wait cycles -> t1_we = 1, t1_addr and t1_wdata match and stay stable throughout, cpu_ready 6 clocks after the sampling edge.
- Back-to-back: RAM load immediately followed by MMIO load with cpu_req held -> two cpu_ready pulses 3 cycles apart, correct target each time, no overlap of t0_req and t1_req.
- Stray acks: t1_ack pulses during a t0 access, and t0_ack pulses in IDLE -> no state change, cpu_ready stays 0 until t0_ack.
- Reset mid-access: rst asserted in ACCESS before ack -> tN_req = 0 and cpu_ready = 0 immediately; after release, a fresh request completes normally.
- BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES = 16, target never acks -> cpu_ready with cpu_err = 1 and cpu_rdata = 0 after 16 ACCESS cycles. A separate run acks on cycle 16 -> cpu_err = 0.
